col_moment_acc: RTL and testbench

- Downstream consumer of the per-column weighting stage in the FAST/ORB orientation path.
- Collects the 31 per-column results of one patch: the column sum and the column sum × |column offset|.
- Produces the patch moments: m00 is the sum of all pixels; m10 is the signed, column-offset-weighted sum.
- Hands the moments to the angle/atan stage over a valid/ready handshake.

---
 rtl/orb_pkg.sv | 21 ++
 rtl/col_moment_sign_add.sv | 23 ++
 rtl/col_moment_acc.sv | 126 ++++++++++++
 tb/tb_col_moment_acc.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orb_pkg.sv
// Shared constants, FSM state type and column-offset helper for the ORB
// orientation path.
package orb_pkg;

   localparam int unsigned PATCH_N   = 31;
   localparam int unsigned PATCH_CTR = 15;
   localparam int unsigned PIX_W     = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } acc_state_t;

   // |c - PATCH_CTR|: the offset index the weighting stage tags column c with
   function automatic logic [3:0] exp_idx(input logic [4:0] c);
      if (32'(c) < PATCH_CTR) return 4'(PATCH_CTR - 32'(c));
      else                    return 4'(32'(c) - PATCH_CTR);
   endfunction

endpackage

// File: rtl/col_moment_sign_add.sv
// Adds or subtracts one unsigned weighted column product into the signed
// m10 accumulator, depending on which side of the centre the column lies.
module col_moment_sign_add #(
   parameter int unsigned MULT_W = 20,
   parameter int unsigned ACC_W  = 26
) (
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [MULT_W-1:0] mult,
   input  logic              neg,
   input  logic              en,
   output logic [ACC_W-1:0]  acc_out
);

   logic [ACC_W-1:0] mult_x;

   assign mult_x = {{(ACC_W-MULT_W){1'b0}}, mult};

   always_comb begin
      acc_out = acc_in;
      if (en) acc_out = neg ? (acc_in - mult_x) : (acc_in + mult_x);
   end

endmodule

// File: rtl/col_moment_acc.sv
// Accumulates the per-column results of one patch into m00/m10 and hands
// them downstream over valid/ready. COL_MOMENT_CHK_EN adds the column-index check.
module col_moment_acc
   import orb_pkg::*;
#(
   parameter int unsigned NCOL   = PATCH_N,
   parameter int unsigned SUM_W  = 2 * PIX_W,
   parameter int unsigned MULT_W = 20,
   parameter int unsigned M00_W  = 21,
   parameter int unsigned M10_W  = 26
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              col_valid,
   input  logic [SUM_W-1:0]  col_sum,
   input  logic [MULT_W-1:0] col_mult,
   input  logic [3:0]        col_index,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [M00_W-1:0]  m00,
   output logic [M10_W-1:0]  m10,
   output logic              err_ovf,
   output logic              err_idx
);

   localparam int unsigned CTR   = (NCOL - 1) / 2;
   localparam int unsigned CNT_W = $clog2(NCOL);

   acc_state_t       state, state_nxt;
   logic [CNT_W-1:0] col_cnt;
   logic [M00_W-1:0] acc00, acc00_nxt, m00_q;
   logic [M10_W-1:0] acc10, acc10_nxt, m10_q;
   logic             accept, last, ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      ovf       = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (col_valid) begin
                  accept    = 1'b1;
                  last      = (col_cnt == CNT_W'(NCOL - 1));
                  state_nxt = last ? HOLD : ACCUM;
               end
            end
            HOLD: begin
               ovf = col_valid;
               if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign acc00_nxt = acc00 + M00_W'(col_sum);

   col_moment_sign_add #(
      .MULT_W (MULT_W),
      .ACC_W  (M10_W)
   ) u_sign_add (
      .acc_in  (acc10),
      .mult    (col_mult),
      .neg     (col_cnt < CNT_W'(CTR)),
      .en      (col_cnt != CNT_W'(CTR)),
      .acc_out (acc10_nxt)
   );

   // Accumulators are zeroed on the final column so IDLE always starts from 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
         acc00   <= '0;
         acc10   <= '0;
         m00_q   <= '0;
         m10_q   <= '0;
      end else if (clr) begin
         col_cnt <= '0;
         acc00   <= '0;
         acc10   <= '0;
      end else if (accept) begin
         if (last) begin
            col_cnt <= '0;
            acc00   <= '0;
            acc10   <= '0;
            m00_q   <= acc00_nxt;
            m10_q   <= acc10_nxt;
         end else begin
            col_cnt <= col_cnt + 1'b1;
            acc00   <= acc00_nxt;
            acc10   <= acc10_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_ovf <= 1'b0;
      else if (ovf) err_ovf <= 1'b1;
   end

`ifdef COL_MOMENT_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_idx <= 1'b0;
      else if (accept && (col_index != exp_idx(5'(col_cnt)))) err_idx <= 1'b1;
   end
`else
   logic unused_idx;
   assign unused_idx = ^col_index;
   assign err_idx    = 1'b0;
`endif

   assign m_valid = (state == HOLD);
   assign m00     = m00_q;
   assign m10     = m10_q;

endmodule

// File: tb/tb_col_moment_acc.sv
// Randomized self-checking bench for col_moment_acc against a per-patch
// sum model.
module tb_col_moment_acc;

   localparam int NCOL = 31;
   localparam int CTR  = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        col_valid = 1'b0;
   logic [15:0] col_sum = '0;
   logic [19:0] col_mult = '0;
   logic [3:0]  col_index = '0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [20:0] m00;
   logic [25:0] m10;
   logic        err_ovf;
   logic        err_idx;

   int tests_run = 0;
   int tests_failed = 0;

   int unsigned p_sum  [NCOL];
   int unsigned p_mult [NCOL];
   int unsigned p_idx  [NCOL];

   col_moment_acc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .col_valid (col_valid),
      .col_sum   (col_sum),
      .col_mult  (col_mult),
      .col_index (col_index),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m00       (m00),
      .m10       (m10),
      .err_ovf   (err_ovf),
      .err_idx   (err_idx)
   );

   always #5 clk = ~clk;

   function automatic longint ref_m00();
      longint s = 0;
      for (int c = 0; c < NCOL; c++) s += longint'(p_sum[c]);
      return s;
   endfunction

   function automatic longint ref_m10();
      longint s = 0;
      for (int c = 0; c < NCOL; c++) begin
         if (c < CTR)      s -= longint'(p_mult[c]);
         else if (c > CTR) s += longint'(p_mult[c]);
      end
      return s;
   endfunction

   function automatic int unsigned offs(input int c);
      return (c < CTR) ? CTR - c : c - CTR;
   endfunction

   task automatic fill_random();
      for (int c = 0; c < NCOL; c++) begin
         p_sum[c]  = $urandom_range(0, 65535);
         p_mult[c] = $urandom_range(0, 1048575);
         p_idx[c]  = offs(c);
      end
   endtask

   task automatic fill_const(input int unsigned s, input int unsigned m);
      for (int c = 0; c < NCOL; c++) begin
         p_sum[c]  = s;
         p_mult[c] = m;
         p_idx[c]  = offs(c);
      end
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic drive_cols(input int first, input int last, input int gapmax);
      for (int c = first; c <= last; c++) begin
         repeat ($urandom_range(0, gapmax)) begin
            @(posedge clk);
            #1;
         end
         col_valid = 1'b1;
         col_sum   = 16'(p_sum[c]);
         col_mult  = 20'(p_mult[c]);
         col_index = 4'(p_idx[c]);
         @(posedge clk);
         #1;
         col_valid = 1'b0;
      end
   endtask

   task automatic wait_valid(output bit ok, output int cycles);
      cycles = 0;
      @(negedge clk);
      while (!m_valid && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      ok = m_valid;
   endtask

   task automatic check_result(input string name);
      bit ok;
      int cyc;
      logic [20:0] e00;
      logic [25:0] e10;
      e00 = 21'(ref_m00());
      e10 = 26'(ref_m10());
      wait_valid(ok, cyc);
      tests_run++;
      if (ok !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_valid: m_valid never rose within 40 cycles", name);
      end
      tests_run++;
      if (m00 !== e00) begin
         tests_failed++;
         $display("FAIL %s_m00: got %0d expected %0d", name, m00, e00);
      end
      tests_run++;
      if (m10 !== e10) begin
         tests_failed++;
         $display("FAIL %s_m10: got %0d expected %0d", name, $signed(m10), $signed(e10));
      end
   endtask

   task automatic test_reset();
      tests_run++;
      if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
      tests_run++;
      if (m00 !== 21'd0) begin tests_failed++; $display("FAIL reset_m00: got %0d expected 0", m00); end
      tests_run++;
      if (m10 !== 26'd0) begin tests_failed++; $display("FAIL reset_m10: got %0d expected 0", m10); end
      tests_run++;
      if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_err_ovf: got %b expected 0", err_ovf); end
      tests_run++;
      if (err_idx !== 1'b0) begin tests_failed++; $display("FAIL reset_err_idx: got %b expected 0", err_idx); end
   endtask

   task automatic test_basic();
      bit ok;
      int cyc;
      m_ready = 1'b1;
      for (int c = 0; c < NCOL; c++) begin
         p_sum[c]  = 10;
         p_mult[c] = 10 * offs(c);
         p_idx[c]  = offs(c);
      end
      drive_cols(0, NCOL - 1, 2);
      wait_valid(ok, cyc);
      tests_run++;
      if (!ok || cyc != 0) begin
         tests_failed++;
         $display("FAIL basic_latency: m_valid after %0d extra cycles (ok=%b) expected 0", cyc, ok);
      end
      tests_run++;
      if (m00 !== 21'd310) begin tests_failed++; $display("FAIL basic_m00: got %0d expected 310", m00); end
      tests_run++;
      if (m10 !== 26'd0) begin tests_failed++; $display("FAIL basic_m10: got %0d expected 0", $signed(m10)); end
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_pulse: m_valid got %b expected 0", m_valid); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_side();
      fill_const(0, 0);
      p_mult[30] = 100;
      drive_cols(0, NCOL - 1, 1);
      check_result("side_plus");
      @(posedge clk);
      #1;
      fill_const(0, 0);
      p_mult[0] = 100;
      drive_cols(0, NCOL - 1, 1);
      check_result("side_minus");
      @(posedge clk);
      #1;
   endtask

   task automatic test_max();
      fill_const(65535, 0);
      for (int c = CTR + 1; c < NCOL; c++) p_mult[c] = 1048575;
      drive_cols(0, NCOL - 1, 0);
      check_result("max");
      tests_run++;
      if (m00 !== 21'd2031585 || m10 !== 26'd15728625) begin
         tests_failed++;
         $display("FAIL max_abs: got %0d/%0d expected 2031585/15728625", m00, m10);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         fill_random();
         drive_cols(0, NCOL - 1, 3);
         check_result("random");
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_hold_ovf();
      logic [20:0] e00;
      logic [25:0] e10;
      m_ready = 1'b0;
      fill_random();
      e00 = 21'(ref_m00());
      e10 = 26'(ref_m10());
      drive_cols(0, NCOL - 1, 1);
      for (int k = 0; k < 5; k++) begin
         col_valid = 1'b1;
         col_sum   = 16'($urandom_range(1, 65535));
         col_mult  = 20'($urandom_range(1, 1048575));
         @(negedge clk);
         tests_run++;
         if (m_valid !== 1'b1 || m00 !== e00 || m10 !== e10) begin
            tests_failed++;
            $display("FAIL hold_stable: got v=%b %0d/%0d expected v=1 %0d/%0d", m_valid, m00, m10, e00, e10);
         end
         @(posedge clk);
         #1;
      end
      col_valid = 1'b0;
      tests_run++;
      if (err_ovf !== 1'b1) begin tests_failed++; $display("FAIL hold_err_ovf: got %b expected 1", err_ovf); end
      // handshake cycle with a column that must be dropped
      m_ready   = 1'b1;
      col_valid = 1'b1;
      col_sum   = 16'd999;
      col_mult  = 20'd999;
      @(posedge clk);
      #1;
      col_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_release: m_valid got %b expected 0", m_valid); end
      @(posedge clk);
      #1;
      fill_random();
      drive_cols(0, NCOL - 1, 1);
      check_result("after_hold");
      @(posedge clk);
      #1;
   endtask

   task automatic test_clr();
      fill_random();
      drive_cols(0, 9, 1);
      clr       = 1'b1;
      col_valid = 1'b1;
      col_sum   = 16'd5000;
      col_mult  = 20'd5000;
      @(posedge clk);
      #1;
      clr       = 1'b0;
      col_valid = 1'b0;
      fill_random();
      for (int c = 0; c < NCOL; c++) p_sum[c] = 1;
      drive_cols(0, NCOL - 1, 1);
      check_result("clr_mid");
      tests_run++;
      if (err_ovf !== 1'b1) begin tests_failed++; $display("FAIL clr_keeps_err: err_ovf got %b expected 1", err_ovf); end
      @(posedge clk);
      #1;
      // clr while a result is held drops it
      m_ready = 1'b0;
      fill_random();
      drive_cols(0, NCOL - 1, 0);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_hold: m_valid got %b expected 0", m_valid); end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      fill_random();
      drive_cols(0, 9, 1);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (err_ovf !== 1'b0 || m_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_flags: err_ovf=%b m_valid=%b expected 0/0", err_ovf, m_valid);
      end
      @(posedge clk);
      #1;
      fill_random();
      for (int c = 0; c < NCOL; c++) p_sum[c] = 1;
      drive_cols(0, NCOL - 1, 1);
      check_result("reset_mid");
      @(posedge clk);
      #1;
   endtask

   task automatic test_idx();
      logic exp_err;
`ifdef COL_MOMENT_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      tests_run++;
      if (err_idx !== 1'b0) begin tests_failed++; $display("FAIL idx_pre: err_idx got %b expected 0", err_idx); end
      fill_random();
      p_idx[0] = 3;
      drive_cols(0, NCOL - 1, 1);
      check_result("idx");
      tests_run++;
      if (err_idx !== exp_err) begin tests_failed++; $display("FAIL idx_flag: err_idx got %b expected %b", err_idx, exp_err); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_basic();
      test_side();
      test_max();
      test_random();
      test_hold_ovf();
      test_clr();
      test_reset_mid();
      test_idx();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
